logic_unit_pipe: RTL and testbench

Parametrised, pipelined bitwise logic unit: the next generation of the 4-bit NOT block in BinaryLogic. It applies one of eight bitwise operations to two WIDTH-bit operands, registers the result with status flags, and moves data through valid/ready handshakes on both sides. It sits between operand issue and the result bus of the step-2 datapath, and can absorb output back-pressure without losing data.

---
 rtl/logic_unit_pipe_pkg.sv | 21 ++
 rtl/logic_core.sv | 47 ++++
 rtl/logic_unit_pipe.sv | 96 +++++++++
 tb/tb_logic_unit_pipe.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pipe_pkg.sv
// Shared opcode encodings and control-state type for the pipelined logic unit.
// Kept in a package so the core and the bench decode opcodes identically.
package logic_unit_pipe_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOT  = 3'd0;
  localparam logic [OP_W-1:0] OP_AND  = 3'd1;
  localparam logic [OP_W-1:0] OP_OR   = 3'd2;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_NAND = 3'd4;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
  localparam logic [OP_W-1:0] OP_PASS = 3'd7;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/logic_core.sv
// Combinational bitwise core: opcode decode, result and its status flags.
// The only place opcodes are interpreted.
module logic_core
  import logic_unit_pipe_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int PC_W  = $clog2(WIDTH + 1)
) (
  input  logic [OP_W-1:0]  i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_ones,
  output logic             o_parity,
  output logic [PC_W-1:0]  o_popcnt
);

  logic [WIDTH-1:0] w_res;
  logic [PC_W-1:0]  w_cnt;

  always_comb begin
    w_res = i_a;
    case (i_op)
      OP_NOT:  w_res = ~i_a;
      OP_AND:  w_res = i_a & i_b;
      OP_OR:   w_res = i_a | i_b;
      OP_XOR:  w_res = i_a ^ i_b;
      OP_NAND: w_res = ~(i_a & i_b);
      OP_NOR:  w_res = ~(i_a | i_b);
      OP_XNOR: w_res = ~(i_a ^ i_b);
      default: w_res = i_a;
    endcase
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < WIDTH; i++) w_cnt = w_cnt + PC_W'(w_res[i]);
  end

  assign o_result = w_res;
  assign o_zero   = ~|w_res;
  assign o_ones   = &w_res;
  assign o_parity = ^w_res;
  assign o_popcnt = w_cnt;

endmodule

// File: rtl/logic_unit_pipe.sv
// One-deep registered logic unit with valid/ready on both sides.
// A full slot can be drained and refilled in the same cycle, so streaming has no bubbles.
module logic_unit_pipe
  import logic_unit_pipe_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [OP_W-1:0]              op,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             result,
  output logic                         zero,
  output logic                         ones,
  output logic                         parity,
  output logic [$clog2(WIDTH+1)-1:0]   popcnt,
  output logic [CNT_W-1:0]             op_count
);

  localparam int PC_W = $clog2(WIDTH + 1);

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_result;
  logic             r_zero, r_ones, r_parity;
  logic [PC_W-1:0]  r_popcnt;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_result;
  logic             w_zero, w_ones, w_parity;
  logic [PC_W-1:0]  w_popcnt;
  logic             w_accept, w_deliver;

  logic_core #(.WIDTH(WIDTH), .PC_W(PC_W)) u_core (
    .i_op     (op),
    .i_a      (a),
    .i_b      (b),
    .o_result (w_result),
    .o_zero   (w_zero),
    .o_ones   (w_ones),
    .o_parity (w_parity),
    .o_popcnt (w_popcnt)
  );

  // Ready depends only on registered state and the consumer, never on in_valid.
  assign in_ready  = (r_state == ST_EMPTY) | out_ready;
  assign w_accept  = in_valid & in_ready;
  assign w_deliver = (r_state == ST_FULL) & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
      ST_FULL:  if (w_deliver && !w_accept) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Result and flags move only on accept; a drain alone leaves them as they were.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_zero   <= 1'b0;
      r_ones   <= 1'b0;
      r_parity <= 1'b0;
      r_popcnt <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_result <= w_result;
      r_zero   <= w_zero;
      r_ones   <= w_ones;
      r_parity <= w_parity;
      r_popcnt <= w_popcnt;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign result    = r_result;
  assign zero      = r_zero;
  assign ones      = r_ones;
  assign parity    = r_parity;
  assign popcnt    = r_popcnt;
  assign op_count  = r_cnt;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed scoreboard bench: expected results queued on accept, checked on deliver.
// Also covers stall hold, async reset mid-stall, counter wrap and WIDTH=1/32 builds.
module tb_logic_unit_pipe;
  import logic_unit_pipe_pkg::*;

  typedef struct packed {
    logic [3:0] res;
    logic       z;
    logic       o;
    logic       p;
    logic [2:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // main DUT, WIDTH=4 CNT_W=16
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  op;
  logic [3:0]  a, b, result;
  logic        zero, ones, parity;
  logic [2:0]  popcnt;
  logic [15:0] op_count;

  // WIDTH=1 CNT_W=3
  logic        v1, rdy1, ov1, ordy1;
  logic [2:0]  op1;
  logic [0:0]  a1, b1, res1;
  logic        z1, o1, p1;
  logic [0:0]  pc1;
  logic [2:0]  cnt1;

  // WIDTH=32 CNT_W=3
  logic        v32, rdy32, ov32, ordy32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, res32;
  logic        z32, o32, p32;
  logic [5:0]  pc32;
  logic [2:0]  cnt32;

  logic_unit_pipe #(.WIDTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .ones(ones), .parity(parity), .popcnt(popcnt), .op_count(op_count)
  );

  logic_unit_pipe #(.WIDTH(1), .CNT_W(3)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .op(op1),
    .a(a1), .b(b1), .out_valid(ov1), .out_ready(ordy1), .result(res1),
    .zero(z1), .ones(o1), .parity(p1), .popcnt(pc1), .op_count(cnt1)
  );

  logic_unit_pipe #(.WIDTH(32), .CNT_W(3)) dut_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32), .op(op32),
    .a(a32), .b(b32), .out_valid(ov32), .out_ready(ordy32), .result(res32),
    .zero(z32), .ones(o32), .parity(p32), .popcnt(pc32), .op_count(cnt32)
  );

  int   n_vec = 0;
  int   n_err = 0;
  int   exp_cnt = 0;
  exp_t q[$];

  function automatic exp_t mk(logic [3:0] r);
    exp_t e;
    e.res = r;
    e.pc  = 3'd0;
    e.p   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e.pc = e.pc + {2'b00, r[i]};
      e.p  = e.p ^ r[i];
    end
    e.z = (e.pc == 3'd0);
    e.o = (e.pc == 3'd4);
    return e;
  endfunction

  function automatic logic [3:0] ref_op(logic [2:0] o, logic [3:0] x, logic [3:0] y);
    case (o)
      3'd0: return ~x;
      3'd1: return x & y;
      3'd2: return x | y;
      3'd3: return x ^ y;
      3'd4: return ~(x & y);
      3'd5: return ~(x | y);
      3'd6: return ~(x ^ y);
      default: return x;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle from a negedge; score deliver/accept, end on the next negedge.
  task automatic drive(input logic v, input logic [2:0] o, input logic [3:0] aa,
                       input logic [3:0] bb, input logic ordy, input logic [3:0] exp_r);
    exp_t e;
    in_valid = v; op = o; a = aa; b = bb; out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_vec++; n_err++;
        $error("FAIL sb_underflow observed=deliver expected=no_result_pending");
      end else begin
        e = q.pop_front();
        chk("result", 64'(result), 64'(e.res));
        chk("zero",   64'(zero),   64'(e.z));
        chk("ones",   64'(ones),   64'(e.o));
        chk("parity", 64'(parity), 64'(e.p));
        chk("popcnt", 64'(popcnt), 64'(e.pc));
      end
    end
    if (in_valid && in_ready) begin
      q.push_back(mk(exp_r));
      exp_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] sweep_exp [8];
    logic [3:0] ra, rb;
    logic [2:0] ro;
    sweep_exp = '{4'b0011, 4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b1100};

    in_valid = 0; op = 0; a = 0; b = 0; out_ready = 0;
    v1 = 0; op1 = 0; a1 = 0; b1 = 0; ordy1 = 1;
    v32 = 0; op32 = 0; a32 = 0; b32 = 0; ordy32 = 1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_result",    64'(result),    64'(0));
    chk("rst_flags",     64'({zero, ones, parity, popcnt}), 64'(0));
    chk("rst_op_count",  64'(op_count),  64'(0));
    chk("rst_in_ready",  64'(in_ready),  64'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // NOT, then NOT of the complement
    drive(1, OP_NOT, 4'b1001, 4'b0000, 1, 4'b0110);
    chk("lat1_out_valid", 64'(out_valid), 64'(1));
    drive(1, OP_NOT, 4'b0110, 4'b0000, 1, 4'b1001);

    // all eight opcodes on a=1100 b=1010
    for (int i = 0; i < 8; i++)
      drive(1, 3'(i), 4'b1100, 4'b1010, 1, sweep_exp[i]);
    drive(0, OP_NOT, 4'b0000, 4'b0000, 1, 4'b0000);
    chk("sweep_op_count", 64'(op_count), 64'(exp_cnt));
    chk("drain_out_valid", 64'(out_valid), 64'(0));
    chk("drain_hold_result", 64'(result), 64'(4'b1100));

    // back-pressure: result held, new inputs ignored
    drive(1, OP_PASS, 4'b1111, 4'b0000, 1, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      drive(1, OP_NOT, 4'b1111, 4'b0000, 0, 4'b0000);
      chk("stall_in_ready", 64'(in_ready), 64'(0));
      chk("stall_result",   64'(result),   64'(4'b1111));
      chk("stall_ones",     64'(ones),     64'(1));
      chk("stall_valid",    64'(out_valid), 64'(1));
    end
    drive(1, OP_AND, 4'b0101, 4'b0011, 1, 4'b0001);
    drive(0, OP_NOT, 4'b0000, 4'b0000, 1, 4'b0000);

    // streaming, no bubbles
    for (int i = 0; i < 10; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      ro = 3'(i % 8);
      drive(1, ro, ra, rb, 1, ref_op(ro, ra, rb));
      chk("stream_no_bubble", 64'(out_valid), 64'(1));
    end
    drive(0, OP_NOT, 4'b0000, 4'b0000, 1, 4'b0000);
    chk("stream_op_count", 64'(op_count), 64'(exp_cnt));
    chk("stream_queue_empty", 64'(q.size()), 64'(0));

    // async reset while stalled with a pending result
    drive(1, OP_XOR, 4'b1010, 4'b0100, 1, 4'b1110);
    in_valid = 0; out_ready = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_result",    64'(result),    64'(0));
    chk("arst_flags",     64'({zero, ones, parity, popcnt}), 64'(0));
    chk("arst_op_count",  64'(op_count),  64'(0));
    chk("arst_in_ready",  64'(in_ready),  64'(1));
    q.delete();
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, OP_OR, 4'b0001, 4'b0010, 1, 4'b0011);
    drive(0, OP_NOT, 4'b0000, 4'b0000, 1, 4'b0000);
    chk("post_rst_op_count", 64'(op_count), 64'(1));

    // WIDTH=1 and WIDTH=32: NOT of zero
    v1 = 1; op1 = OP_NOT; a1 = 1'b0;
    v32 = 1; op32 = OP_NOT; a32 = 32'h0;
    @(posedge clk); @(negedge clk);
    v1 = 0;
    chk("w1_result", 64'(res1), 64'(1));
    chk("w1_ones",   64'(o1),   64'(1));
    chk("w1_zero",   64'(z1),   64'(0));
    chk("w1_popcnt", 64'(pc1),  64'(1));
    chk("w1_parity", 64'(p1),   64'(1));
    chk("w32_result", 64'(res32), 64'(32'hFFFF_FFFF));
    chk("w32_ones",   64'(o32),   64'(1));
    chk("w32_popcnt", 64'(pc32),  64'(32));
    chk("w32_parity", 64'(p32),   64'(0));
    // nine more into the 3-bit counter: 10 total wraps to 2
    for (int i = 0; i < 9; i++) begin
      op32 = OP_PASS;
      a32 = $urandom;
      @(posedge clk); @(negedge clk);
      chk("w32_pass", 64'(res32), 64'(a32));
    end
    v32 = 0;
    @(posedge clk); @(negedge clk);
    chk("w32_op_count_wrap", 64'(cnt32), 64'(2));
    chk("w1_op_count", 64'(cnt1), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
